// File: rtl/pattern_stream_generator.sv
// pattern_stream_generator
//   Synthetic pixel-stream source used in place of the framebuffer during
//   bring-up. Each slice is a burst of WORDS_PER_SLICE valid words followed
//   by BLANKING_CYCLES idle cycles. sync marks the blanking after the last
//   slice of a turn. The pattern is selected by mode and latched at each
//   slice start.
//
//   Ports:
//     clk_33     in   pixel clock
//     nrst       in   async active-low reset
//     enable     in   run request (checked only at slice boundaries)
//     mode       in   0 SOLID, 1 RAMP, 2 CHECKER, 3 WALK
//     data       out  pattern word (0 outside valid cycles)
//     data_valid out  data holds a valid word
//     sync       out  high through the end-of-turn blanking
//     slice_idx  out  slice currently on the outputs
//
//   Optional: define PATGEN_SLICE_STAMP_EN to overwrite the top slice_idx
//   bits of the first word of every slice with the slice number.
module pattern_stream_generator #(
  parameter int DATA_WIDTH      = 30,
  parameter int WORDS_PER_SLICE = 512,
  parameter int BLANKING_CYCLES = 72,
  parameter int SLICES_PER_TURN = 128,
  parameter int TOGGLE_TURNS    = 256,
  localparam int SLICE_W        = $clog2(SLICES_PER_TURN)
) (
  input  logic                  clk_33,
  input  logic                  nrst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  output logic                  sync,
  output logic [SLICE_W-1:0]    slice_idx
);

  localparam int WORD_W  = $clog2(WORDS_PER_SLICE);
  localparam int BLANK_W = (BLANKING_CYCLES > 1) ? $clog2(BLANKING_CYCLES) : 1;
  localparam int TURN_W  = (TOGGLE_TURNS > 1) ? $clog2(TOGGLE_TURNS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] BLANK  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [WORD_W-1:0]     word_cnt_q, word_cnt_d;
  logic [BLANK_W-1:0]    blank_cnt_q, blank_cnt_d;
  logic [SLICE_W-1:0]    slice_cnt_q, slice_cnt_d;
  logic [TURN_W-1:0]     turn_cnt_q, turn_cnt_d;
  logic                  polarity_q, polarity_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] walk_q, walk_d;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  sync_q, sync_d;
  logic [SLICE_W-1:0]    slice_idx_q, slice_idx_d;

  // Sequencing: IDLE -> ACTIVE (words) -> BLANK -> ACTIVE | IDLE
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    blank_cnt_d = blank_cnt_q;
    slice_cnt_d = slice_cnt_q;
    turn_cnt_d  = turn_cnt_q;
    polarity_d  = polarity_q;
    mode_d      = mode_q;
    walk_d      = walk_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d     = ACTIVE;
          word_cnt_d  = '0;
          slice_cnt_d = '0;
          mode_d      = mode;
          walk_d      = DATA_WIDTH'(1);
        end
      end
      ACTIVE: begin
        if (word_cnt_q == WORD_W'(WORDS_PER_SLICE - 1)) begin
          state_d     = BLANK;
          blank_cnt_d = '0;
          word_cnt_d  = '0;
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
        end
      end
      BLANK: begin
        if (blank_cnt_q == BLANK_W'(BLANKING_CYCLES - 1)) begin
          if (enable) begin
            state_d    = ACTIVE;
            word_cnt_d = '0;
            mode_d     = mode;
            if (slice_cnt_q == SLICE_W'(SLICES_PER_TURN - 1)) begin
              // Turn wrap: walk restarts, turn counter drives SOLID polarity
              slice_cnt_d = '0;
              walk_d      = DATA_WIDTH'(1);
              if (turn_cnt_q == TURN_W'(TOGGLE_TURNS - 1)) begin
                turn_cnt_d = '0;
                polarity_d = ~polarity_q;
              end else begin
                turn_cnt_d = turn_cnt_q + 1'b1;
              end
            end else begin
              slice_cnt_d = slice_cnt_q + 1'b1;
              walk_d      = (walk_q << 1) | (walk_q >> (DATA_WIDTH - 1));
            end
          end else begin
            state_d     = IDLE;
            slice_cnt_d = '0;
            walk_d      = DATA_WIDTH'(1);
          end
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output word for the current state; registered one cycle later
  always_comb begin
    data_d       = '0;
    data_valid_d = 1'b0;
    sync_d       = (state_q == BLANK) && (slice_cnt_q == SLICE_W'(SLICES_PER_TURN - 1));
    slice_idx_d  = slice_cnt_q;
    if (state_q == ACTIVE) begin
      data_valid_d = 1'b1;
      case (mode_q)
        2'd0:    data_d = polarity_q ? '1 : '0;
        2'd1:    data_d = DATA_WIDTH'(word_cnt_q);
        2'd2:    data_d = (word_cnt_q[0] ^ slice_cnt_q[0]) ? '1 : '0;
        default: data_d = walk_q;
      endcase
`ifdef PATGEN_SLICE_STAMP_EN
      if (word_cnt_q == '0) data_d[DATA_WIDTH-1 -: SLICE_W] = slice_cnt_q;
`endif
    end
  end

  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      blank_cnt_q  <= '0;
      slice_cnt_q  <= '0;
      turn_cnt_q   <= '0;
      polarity_q   <= 1'b0;
      mode_q       <= 2'd0;
      walk_q       <= DATA_WIDTH'(1);
      data_q       <= '0;
      data_valid_q <= 1'b0;
      sync_q       <= 1'b0;
      slice_idx_q  <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      blank_cnt_q  <= blank_cnt_d;
      slice_cnt_q  <= slice_cnt_d;
      turn_cnt_q   <= turn_cnt_d;
      polarity_q   <= polarity_d;
      mode_q       <= mode_d;
      walk_q       <= walk_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      sync_q       <= sync_d;
      slice_idx_q  <= slice_idx_d;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign sync       = sync_q;
  assign slice_idx  = slice_idx_q;

endmodule

// File: tb/tb_pattern_stream_generator.sv
// Bench for pattern_stream_generator with a small geometry
// (8 words, 4 blanking, 4 slices/turn, polarity flip every 2 turns).
// Reference: a position-in-slice model; patterns computed arithmetically.
module tb_pattern_stream_generator;
  localparam int DW = 30;
  localparam int W  = 8;
  localparam int B  = 4;
  localparam int S  = 4;
  localparam int T  = 2;
  localparam int SW = 2;

  logic          clk_33 = 1'b0;
  logic          nrst   = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    mode   = 2'd0;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          sync;
  logic [SW-1:0] slice_idx;

  always #15 clk_33 = ~clk_33;

  pattern_stream_generator #(
    .DATA_WIDTH(DW), .WORDS_PER_SLICE(W), .BLANKING_CYCLES(B),
    .SLICES_PER_TURN(S), .TOGGLE_TURNS(T)
  ) dut (
    .clk_33(clk_33), .nrst(nrst), .enable(enable), .mode(mode),
    .data(data), .data_valid(data_valid), .sync(sync), .slice_idx(slice_idx)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // model: running flag, position within slice+blanking, slice, completed turns
  bit            m_run;
  int            m_pos, m_s, m_turns;
  logic [1:0]    m_mode;
  logic [DW-1:0] e_data;
  logic          e_valid, e_sync;
  logic [SW-1:0] e_slice;

  function automatic logic [DW-1:0] pattern(int w, int s, logic [1:0] md, int turns);
    logic [DW-1:0] p;
    case (md)
      2'd0:    p = (((turns / T) % 2) == 1) ? '1 : '0;
      2'd1:    p = DW'(w);
      2'd2:    p = (((w ^ s) & 1) == 1) ? '1 : '0;
      default: p = DW'(1) << (s % DW);
    endcase
`ifdef PATGEN_SLICE_STAMP_EN
    if (w == 0) p[DW-1 -: SW] = SW'(s);
`endif
    return p;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_s = 0; m_turns = 0; m_mode = 2'd0;
    e_data = '0; e_valid = 1'b0; e_sync = 1'b0; e_slice = '0;
  endtask

  // Called at each rising edge: outputs reflect pre-edge position, then advance
  task automatic model_edge();
    if (!nrst) begin
      model_reset();
      return;
    end
    e_slice = SW'(m_s);
    e_valid = m_run && (m_pos < W);
    e_data  = e_valid ? pattern(m_pos, m_s, m_mode, m_turns) : '0;
    e_sync  = m_run && (m_pos >= W) && (m_s == S - 1);
    if (!m_run) begin
      if (enable) begin m_run = 1; m_pos = 0; m_s = 0; m_mode = mode; end
    end else if (m_pos < W + B - 1) begin
      m_pos++;
    end else if (enable) begin
      m_pos  = 0;
      m_mode = mode;
      if (m_s == S - 1) begin m_s = 0; m_turns++; end
      else m_s++;
    end else begin
      m_run = 0; m_s = 0;
    end
  endtask

  task automatic check_outputs();
    n_assert++;
    assert (data_valid === e_valid) else begin
      n_fail++; $error("FAIL data_valid got=%0b exp=%0b t=%0t", data_valid, e_valid, $time);
    end
    n_assert++;
    assert (data === e_data) else begin
      n_fail++; $error("FAIL data got=%h exp=%h t=%0t", data, e_data, $time);
    end
    n_assert++;
    assert (sync === e_sync) else begin
      n_fail++; $error("FAIL sync got=%0b exp=%0b t=%0t", sync, e_sync, $time);
    end
    n_assert++;
    assert (slice_idx === e_slice) else begin
      n_fail++; $error("FAIL slice_idx got=%0d exp=%0d t=%0t", slice_idx, e_slice, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_33);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the internal position reaches slice s (s<0: any) word p
  task automatic wait_pos(input int s, input int p);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      found = m_run && (m_pos == p) && (s < 0 || m_s == s);
    end
    n_assert++;
    assert (found) else begin
      n_fail++; $error("FAIL wait_pos s=%0d p=%0d got=timeout exp=reached", s, p);
    end
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs();                      // reset state
    enable = 1'b1; mode = 2'd1;
    ticks(2);                             // reset held: enable ignored
    nrst = 1'b1;

    // Framing with RAMP across two turns
    ticks(2 * S * (W + B));

    // Mode change mid-slice is deferred to the next slice start
    wait_pos(-1, 3);
    mode = 2'd2;
    ticks(2 * (W + B));

    // WALK across a turn boundary
    mode = 2'd3;
    ticks(6 * (W + B));

    // SOLID over several turns (polarity flips)
    mode = 2'd0;
    ticks(5 * S * (W + B));

    // Random mode churn, enable held
    for (int i = 0; i < 300; i++) begin
      mode = 2'($urandom_range(0, 3));
      tick();
    end

    // Enable drop mid-slice 1, then restart in WALK
    wait_pos(1, 2);
    enable = 1'b0;
    ticks(W + B + 4);
    mode = 2'd3; enable = 1'b1;
    ticks(2 * (W + B));

    // Async reset mid-slice
    wait_pos(-1, 5);
    #5;
    nrst = 1'b0;
    model_reset();
    #1;
    check_outputs();
    enable = 1'b0;
    ticks(2);
    nrst = 1'b1;
    ticks(3);
    mode = 2'd1; enable = 1'b1;
    ticks(S * (W + B) + 2);

    // Random enable/mode
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      mode   = 2'($urandom_range(0, 3));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pattern_stream_generator.md
Name: pattern_stream_generator

Overview:
Parametrised synthetic pixel-stream source for the driver main controller. It stands in for the real framebuffer during bring-up. Per slice it emits a burst of DATA_WIDTH-bit words with a valid strobe, followed by a blanking gap, and raises sync on the blanking after the last slice of a turn. Four selectable test patterns replace the fixed heartbeat stream.

Parameters:
DATA_WIDTH, 30, width of each data word
WORDS_PER_SLICE, 512, valid words per slice (>=2)
BLANKING_CYCLES, 72, idle cycles after each slice (>=1)
SLICES_PER_TURN, 128, slices per turn (>=2)
TOGGLE_TURNS, 256, turns between SOLID-pattern polarity flips (>=1)

Ports:
clk_33      in   1                          pixel clock
nrst        in   1                          async active-low reset
enable      in   1                          run request
mode        in   2                          0 SOLID, 1 RAMP, 2 CHECKER, 3 WALK
data        out  DATA_WIDTH                 pattern word
data_valid  out  1                          data holds a valid word
sync        out  1                          turn boundary (end-of-turn blanking)
slice_idx   out  $clog2(SLICES_PER_TURN)    slice currently output

Behaviour:
- Reset: one clock; nrst asynchronous, active-low. Asserting it clears all state and outputs immediately, including mid-slice. data=0, data_valid=0, sync=0, slice_idx=0, state=IDLE, word_cnt=0, blank_cnt=0, turn_cnt=0, polarity=0, walk register=1 (bit 0 set).
- Word and slice counts: word_cnt is $clog2(WORDS_PER_SLICE) bits; slice_idx wraps SLICES_PER_TURN-1 -> 0.
- FSM, IDLE -> ACTIVE: enable is sampled high; slice_idx=0, word_cnt=0; mode is latched into mode_q.
- FSM, ACTIVE: word_cnt increments each cycle. At WORDS_PER_SLICE-1 -> BLANK, blank_cnt=0.
- FSM, BLANK: blank_cnt increments. At BLANKING_CYCLES-1:
  - if enable is high -> ACTIVE with slice_idx+1 (wrap), word_cnt=0, mode re-latched;
  - otherwise -> IDLE with slice_idx=0 and the walk register reset to 1.
- Stopping: deasserting enable never truncates a slice or its blanking; the block stops only at a slice boundary.
- mode changes are ignored mid-slice; they take effect only at the latch points above.
- Output timing: data, data_valid and sync are registered, one cycle after the state/counter they reflect. The first data_valid follows the second edge after enable is sampled high in IDLE.
- data_valid is high for exactly WORDS_PER_SLICE consecutive cycles per slice and low otherwise.
- data outside valid cycles is 0.
- sync is high for all BLANKING_CYCLES cycles of the blanking that follows slice SLICES_PER_TURN-1, and 0 elsewhere.
- Patterns, using the word index w and slice s of the word being output:
  - SOLID: all ones if polarity=1, else 0.
  - RAMP: w zero-extended, or truncated to its low DATA_WIDTH bits.
  - CHECKER: all ones if w[0]^s[0], else 0.
  - WALK: the walk register.
- Walk register: rotates left by 1 at each slice start after slice 0, wrapping bit DATA_WIDTH-1 -> bit 0. It is reset to 1 when slice_idx wraps to 0.
- Turn counting: turn_cnt increments at each wrap of slice_idx. At TOGGLE_TURNS-1 it clears and polarity toggles.
- slice_idx is stable throughout a slice and its blanking.

Optional Feature:
PATGEN_SLICE_STAMP_EN
- Defined: on the first valid word of each slice (w=0), the top $clog2(SLICES_PER_TURN) bits of data are replaced by slice_idx; the lower bits keep the pattern. Requires DATA_WIDTH >= $clog2(SLICES_PER_TURN).
- Undefined: data is the pure pattern; no extra logic.

Test Plan:
Test parameters are WORDS_PER_SLICE=8, BLANKING_CYCLES=4, SLICES_PER_TURN=4, TOGGLE_TURNS=2, DATA_WIDTH=30 unless stated.
- Framing: enable=1 held, mode=1 -> each slice shows data_valid high 8 cycles with data 0..7, then low 4 cycles. sync is high only for the 4 cycles after slice 3. The first valid word follows the second edge after enable is sampled.
- CHECKER/WALK: mode=2 -> slice 0 words 0x0,0x3FFFFFFF alternating; slice 1 inverted. mode=3 -> slices 0..3 data 0x1,0x2,0x4,0x8; slice 0 of the next turn is 0x1.
- SOLID toggle: mode=0 -> turns 0-1 data=0, turns 2-3 data=0x3FFFFFFF, turn 4 data=0.
- Mode change mid-slice: mode switches 1->2 at word 3 -> slice finishes as RAMP (3..7); CHECKER starts at the next slice.
- Enable drop: enable=0 at word 2 of slice 1 -> slice 1 completes all 8 words and 4 blanking cycles, then IDLE. The next enable restarts at slice_idx=0 with WALK data 0x1.
- Async reset mid-slice: nrst low at word 5 -> data, data_valid, sync and slice_idx are 0 before the next edge and stay 0 until enable is sampled after nrst releases. With PATGEN_SLICE_STAMP_EN and mode=1, the first word of slice 3 = 0x30000000.
